// File: rtl/hazard_unit.sv
// ID-stage hazard unit. It tracks the destinations of the instructions in EXE, MEM and WB,
// stalls ID on RAW hazards and while MULT is busy, and flushes IF on taken branches.
module hazard_unit #(
  parameter int REG_ADDR_LEN  = 5,
  parameter int MULT_LATENCY  = 4,
  parameter int STALL_CNT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_ADDR_LEN-1:0]  id_src1,
  input  logic [REG_ADDR_LEN-1:0]  id_src2,
  input  logic                     id_two_src,
  input  logic [REG_ADDR_LEN-1:0]  id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_is_mult,
  input  logic                     branch_taken,
  output logic                     hazard_detected,
  output logic                     pc_freeze,
  output logic                     if_flush,
  output logic                     mult_busy,
  output logic [STALL_CNT_LEN-1:0] stall_count
);

  typedef struct packed {
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] dest;
  } slot_t;

  localparam int          NSLOT = 3;  // 0 = EXE, 1 = MEM, 2 = WB
  localparam logic [3:0]  MLOAD = 4'(MULT_LATENCY - 1);

  slot_t      slot [NSLOT];
  logic [3:0] mcnt;
  logic [NSLOT-1:0] hit1, hit2;
  logic       raw, busy, stall, issue;

  // No forwarding: WB still counts because the register file writes on the same edge it is read.
  for (genvar i = 0; i < NSLOT; i++) begin : g_match
    assign hit1[i] = slot[i].wb_en && (slot[i].dest == id_src1) && (id_src1 != '0);
    assign hit2[i] = slot[i].wb_en && (slot[i].dest == id_src2) && (id_src2 != '0);
  end

  assign raw   = id_valid && ((|hit1) || (id_two_src && (|hit2)));
  assign busy  = (mcnt != 4'd0);
  assign stall = !rst && (raw || busy);
  assign issue = id_valid && !stall;

  assign hazard_detected = stall;
  assign pc_freeze       = stall;
  assign mult_busy       = !rst && busy;
  assign if_flush        = !rst && branch_taken && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
      mcnt        <= 4'd0;
      stall_count <= '0;
    end else begin
      slot[2] <= slot[1];
      slot[1] <= slot[0];
      slot[0] <= '{wb_en: id_wb_en && issue, dest: id_dest};
      if (issue && id_is_mult) mcnt <= MLOAD;
      else if (busy)           mcnt <= mcnt - 4'd1;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Produces `hazard_detected` for the ID-stage controller, which squashes `EXE_CMD`, `WB_EN` and `MEM_W_EN` while it is high.
- Keeps a shadow scoreboard of destination registers for the instructions in EXE, MEM and WB.
- Detects read-after-write (RAW) hazards against the instruction in ID.
- Enforces the structural stall of the multi-cycle MULT unit, and issues the IF flush when a branch or jump is taken.
- Sits beside the controller in ID and drives PC and IF/ID register freeze.

Parameters:
- REG_ADDR_LEN, 5, width of register specifiers.
- MULT_LATENCY, 4, cycles MULT occupies EXE (legal range 1..15).
- STALL_CNT_LEN, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_src1  in  REG_ADDR_LEN  first source register of ID instruction.
- id_src2  in  REG_ADDR_LEN  second source register.
- id_two_src  in  1  ID instruction reads src2 (R-type, BNE); 0 for ADDI/JMP.
- id_dest  in  REG_ADDR_LEN  destination of ID instruction.
- id_wb_en  in  1  ID instruction writes `id_dest` (controller `WB_EN`, pre-squash).
- id_is_mult  in  1  ID opcode is MULT.
- branch_taken  in  1  branch/jump resolved taken in ID this cycle.
- hazard_detected  out  1  stall ID; to controller.
- pc_freeze  out  1  hold PC and IF/ID register.
- if_flush  out  1  replace IF/ID contents with bubble next edge.
- mult_busy  out  1  MULT unit occupied.
- stall_count  out  STALL_CNT_LEN  saturating count of stall cycles.

Behaviour:
Scoreboard state:
- Three registered slots, EXE, MEM and WB, each holding {wb_en, dest}.
- Reset: all slots {0, 0}, mult counter 0, `stall_count` 0.

Every clock edge (rst=0):
- WB <= MEM.
- MEM <= EXE.
- EXE <= {id_wb_en & id_valid & ~hazard_detected, id_dest}.
- A stalled cycle therefore inserts a bubble into EXE.

RAW detection (combinational from current slots and ID inputs, zero latency):
- match(s, r) = s.wb_en & (s.dest == r) & (r != 0).
- Register 0 never hazards.
- raw = id_valid & (match(any slot, id_src1) | (id_two_src & match(any slot, id_src2))).
- No forwarding exists; the WB slot counts, because the register file writes at the posedge and reads combinationally before it.

MULT structural stall:
- The 4-bit counter `mcnt` loads MULT_LATENCY-1 at the edge where id_valid & id_is_mult & ~hazard_detected.
- Otherwise it decrements while nonzero.
- mult_busy = (mcnt != 0).
- MULT_LATENCY=1 never sets busy.
- The slot-shift rule is unchanged by MULT.
- While busy, no further issue occurs (`hazard_detected` forces a bubble into EXE).

Outputs:
- hazard_detected = raw | mult_busy.
- pc_freeze = hazard_detected.
- if_flush = branch_taken & ~hazard_detected.
- A branch seen while stalled is ignored; it is re-evaluated once the stall clears.
- `stall_count` increments on each cycle with hazard_detected=1 and saturates at all-ones (no wrap).

Reset:
- rst=1 at any edge clears all state, including mid-MULT.
- While rst=1, all outputs read as 0 except `stall_count`, which holds 0 after the edge.

Simultaneous events:
- MULT in ID with a RAW on its sources: RAW wins, and the counter is not loaded until issue.
- branch_taken with a RAW: no flush that cycle.

Test Plan:
- Reset: hold rst 2 cycles mid-sequence with mcnt=2 -> next cycle all outputs 0, mult_busy=0, stall_count=0.
- Back-to-back RAW: ADD r3 then SUB r5,r3,r4 -> hazard_detected=1 for exactly 3 cycles, released when r3 leaves WB; stall_count=3.
- No false hazards:
  - ADDI r0 followed by a read of r0 -> no stall.
  - ADDI r7 followed by ADDI r8,r7 with id_two_src=0 and src2 field = 7 -> stall on src1 only.
  - Consumer of r7 with id_valid=0 -> no stall.
- MULT: MULT_LATENCY=4, MULT followed by an independent ADD -> mult_busy and hazard_detected high for 3 cycles, then the ADD issues.
- Branch: BNE taken with no hazard -> if_flush=1 for one cycle. BNE taken while r2 (a source) is in MEM -> if_flush=0 during the stall, then 1 on the first non-stalled cycle.
- Saturation: STALL_CNT_LEN=4 with 20 continuous stall cycles -> stall_count stops at 15.
